spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

SPI master transaction controller for the SPI project. It sequences one full-duplex mode-0 frame (CPOL=0, CPHA=0, MSB first) per start request. It generates SCLK from a half-period prescaler and drives chip-select and MOSI. MISO bits are captured into a receive register, with the bit position tracked by a down-counting bit counter (uni_counter-style, MOD = DATA_WIDTH).

## Interface
- DATA_WIDTH, 8, bits per frame; must be ≥ 2
- CLK_DIV, 4, i_clk cycles per SCLK half-period; must be ≥ 1
- i_clk  input  1  system clock; all logic on rising edge
- i_rst  input  1  asynchronous, active-low reset
- i_start  input  1  frame request; sampled only when idle
- i_tx_data  input  DATA_WIDTH  word to transmit; captured in the cycle i_start is accepted
- i_miso  input  1  serial data from slave
- o_sclk  output  1  SPI clock, idle low
- o_mosi  output  1  serial data to slave
- o_cs_n  output  1  chip select, active low
- o_busy  output  1  frame in progress
- o_done  output  1  one-cycle pulse at frame end
- o_rx_data  output  DATA_WIDTH  last received word, held until the next o_done

## Operation
- **Reset values** (asynchronous, while i_rst=0): o_sclk=0, o_mosi=0, o_cs_n=1, o_busy=0, o_done=0, o_rx_data=0, state=IDLE, all counters 0.
- **States:** IDLE, SETUP, HIGH, LOW, HOLD.
- **IDLE:**
  - o_busy=0, o_cs_n=1, o_sclk=0.
  - i_start=1 → go to SETUP. In the same edge, load tx shift register with i_tx_data, set o_mosi=i_tx_data[DATA_WIDTH-1], set o_cs_n=0, set o_busy=1, set bit counter to DATA_WIDTH-1 and prescaler to 0.
- **Prescaler:**
  - Counts 0..CLK_DIV-1 in SETUP/HIGH/LOW/HOLD.
  - A phase ends on the cycle the prescaler equals CLK_DIV-1; it then wraps to 0.
- **SETUP end:**
  - o_sclk←1 and rx shift register ← {rx[DATA_WIDTH-2:0], i_miso}, both on the same edge.
  - Go to HIGH.
- **HIGH end:**
  - o_sclk←0.
  - If bit counter ≠ 0: decrement it, shift tx so that o_mosi = next lower bit, go to LOW.
  - If bit counter = 0: o_mosi unchanged, go to HOLD.
- **LOW end:** o_sclk←1, sample i_miso into rx as in SETUP, go to HIGH.
- **HOLD end:**
  - o_cs_n←1, o_busy←0, o_done←1 for one cycle, o_rx_data←final rx shift value, o_mosi←0.
  - Go to IDLE.
- **Ignored inputs:**
  - i_start while o_busy=1 is ignored. No queuing, and no error is reported.
  - i_tx_data changes after acceptance have no effect on the current frame.
- **Back-to-back:** i_start=1 in the o_done cycle (state is IDLE) is accepted. o_cs_n is then high for exactly one cycle between frames.
- **Bit order:**
  - Bit k of i_tx_data appears on o_mosi during the (DATA_WIDTH-k)th SCLK high period.
  - The first sampled MISO bit lands in o_rx_data[DATA_WIDTH-1].
- **Reset mid-frame:** abort immediately to reset values. There is no o_done, and o_rx_data is cleared to 0.

## Timing
- Latency from i_start accepted (edge E0) to o_cs_n=0, o_busy=1: visible after E0, i.e. 1 cycle.
- SCLK period is 2·CLK_DIV cycles with 50% duty. The first rising edge is CLK_DIV cycles after o_cs_n falls.
- o_busy stays high for exactly CLK_DIV·(2·DATA_WIDTH+1) cycles. With the defaults, 68 cycles.
- Exactly DATA_WIDTH SCLK rising edges occur per frame. o_sclk is always 0 when o_cs_n changes.
- o_mosi changes only on SCLK falling transitions, or at frame start/end. It is stable for the full high phase.
- o_done rises in the first cycle o_busy=0. o_rx_data updates in that same cycle.
- CLK_DIV=1: each phase lasts 1 cycle, and the SETUP/HOLD phases still exist.

## Test plan
- **Loopback:**
  - Stimulus: defaults, i_miso wired to o_mosi, i_start pulse with i_tx_data=0xA5.
  - Required: o_busy high exactly 68 cycles; 8 SCLK rises with period 8 cycles; o_mosi sequence 1,0,1,0,0,1,0,1; o_done single pulse; o_rx_data=0xA5.
- **Independent MISO:**
  - Stimulus: tx=0x00, i_miso driven with pattern 0x3C synchronised to the SCLK rises.
  - Required: o_rx_data=0x3C, o_mosi=0 throughout.
- **Start while busy:**
  - Stimulus: i_start re-asserted with tx=0xFF at cycle 20 of a 0x81 frame.
  - Required: the frame completes unchanged, only one o_done occurs, and o_cs_n returns to 1 with no second frame.
- **Back-to-back:**
  - Stimulus: i_start asserted in the o_done cycle with tx=0x5A after a 0xC3 frame.
  - Required: o_cs_n high for exactly 1 cycle, then the second frame runs. Both o_rx_data values are correct in loopback (0xC3, then 0x5A).
- **Reset mid-frame:**
  - Stimulus: i_rst=0 asynchronously after 3 SCLK rises.
  - Required: outputs take reset values immediately, without waiting for a clock edge; o_rx_data=0; no o_done; a new 0x0F frame after release completes normally.
- **CLK_DIV=1, DATA_WIDTH=16:**
  - Stimulus: loopback with tx=0xBEEF.
  - Required: SCLK period 2 cycles, o_busy high 33 cycles, o_rx_data=0xBEEF.

Source files
------------

// File: rtl/spi_master_ctrl_if.sv
// Bus bundle for the SPI master controller: request/data side plus the serial pins.
// The master modport is the controller's view; the slave modport is the user/pad side.
interface spi_master_ctrl_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  i_start;
  logic [DATA_WIDTH-1:0] i_tx_data;
  logic                  i_miso;
  logic                  o_sclk;
  logic                  o_mosi;
  logic                  o_cs_n;
  logic                  o_busy;
  logic                  o_done;
  logic [DATA_WIDTH-1:0] o_rx_data;

  modport master (
    input  i_start, i_tx_data, i_miso,
    output o_sclk, o_mosi, o_cs_n, o_busy, o_done, o_rx_data
  );

  modport slave (
    output i_start, i_tx_data, i_miso,
    input  o_sclk, o_mosi, o_cs_n, o_busy, o_done, o_rx_data
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 (CPOL=0, CPHA=0, MSB first) master: one full-duplex frame per accepted start.
// Request handshake: i_start is a level sampled only while idle; o_done pulses once per frame end.
module spi_master_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  spi_master_ctrl_if.master    bus,
  output logic [2:0]           o_dbg_state
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [PW-1:0]         r_presc;
  logic [BW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic                  r_sclk;
  logic                  r_mosi;
  logic                  r_cs_n;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  w_phase_end;

  assign w_phase_end = (r_state != IDLE) && (r_presc == PRESC_LAST);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.i_start) w_next_state = SETUP;
      SETUP:   if (w_phase_end) w_next_state = HIGH;
      HIGH:    if (w_phase_end) w_next_state = (r_bit_cnt != '0) ? LOW : HOLD;
      LOW:     if (w_phase_end) w_next_state = HIGH;
      HOLD:    if (w_phase_end) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_presc   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rx_data <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        r_presc <= '0;
        if (bus.i_start) begin
          r_tx      <= bus.i_tx_data;
          r_mosi    <= bus.i_tx_data[DATA_WIDTH-1];
          r_cs_n    <= 1'b0;
          r_busy    <= 1'b1;
          r_bit_cnt <= BIT_LAST;
        end
      end else begin
        r_presc <= w_phase_end ? '0 : r_presc + PW'(1);
        if (w_phase_end) begin
          case (r_state)
            // Rising SCLK edge: sample MISO at the same clock the pin goes high.
            SETUP, LOW: begin
              r_sclk <= 1'b1;
              r_rx   <= {r_rx[DATA_WIDTH-2:0], bus.i_miso};
            end
            HIGH: begin
              r_sclk <= 1'b0;
              if (r_bit_cnt != '0) begin
                r_bit_cnt <= r_bit_cnt - BW'(1);
                r_tx      <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                r_mosi    <= r_tx[DATA_WIDTH-2];
              end
            end
            HOLD: begin
              r_cs_n    <= 1'b1;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_rx_data <= r_rx;
              r_mosi    <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.o_sclk    = r_sclk;
  assign bus.o_mosi    = r_mosi;
  assign bus.o_cs_n    = r_cs_n;
  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
  assign bus.o_rx_data = r_rx_data;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: default build (8 bit, div 4) plus a 16 bit, div 1 build.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- DUT 0: defaults ----------------
  spi_master_ctrl_if #(.DATA_WIDTH(8)) bus0 ();
  logic [2:0] st0;
  logic       loop0 = 1'b1;
  logic       miso_drv = 1'b0;
  assign bus0.i_miso = loop0 ? bus0.o_mosi : miso_drv;

  spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(4)) dut0 (
    .i_clk(clk), .i_rst(rst_n), .bus(bus0), .o_dbg_state(st0)
  );

  // ---------------- DUT 1: 16 bit, CLK_DIV=1 ----------------
  spi_master_ctrl_if #(.DATA_WIDTH(16)) bus1 ();
  logic [2:0] st1;
  assign bus1.i_miso = bus1.o_mosi;

  spi_master_ctrl #(.DATA_WIDTH(16), .CLK_DIV(1)) dut1 (
    .i_clk(clk), .i_rst(rst_n), .bus(bus1), .o_dbg_state(st1)
  );

  // Monitor state, sampled 1 time unit after each rising edge.
  int         cyc = 0;
  int         busy_cnt, rise_cnt, done_cnt, cs_viol, per_min, per_max, last_rise, cs_fall, first_dly;
  logic [7:0] mosi_seq;
  logic [7:0] miso_pat;
  logic       mosi_or;
  logic       prev_sclk = 1'b0, prev_cs = 1'b1;
  int         busy1_cnt, rise1_cnt, per1_min, per1_max, last1_rise;
  logic       prev1_sclk = 1'b0;

  task automatic clear_stats();
    busy_cnt = 0; rise_cnt = 0; done_cnt = 0; cs_viol = 0;
    per_min = 9999; per_max = 0; last_rise = -1; cs_fall = -1; first_dly = -1;
    mosi_seq = '0; mosi_or = 1'b0;
    busy1_cnt = 0; rise1_cnt = 0; per1_min = 9999; per1_max = 0; last1_rise = -1;
  endtask

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (bus0.o_busy) busy_cnt++;
    if (bus0.o_done) done_cnt++;
    if (bus0.o_busy) mosi_or = mosi_or | bus0.o_mosi;
    if (bus0.o_cs_n !== prev_cs && (bus0.o_sclk !== 1'b0 || prev_sclk !== 1'b0)) cs_viol++;
    if (prev_cs && !bus0.o_cs_n) cs_fall = cyc;
    if (!prev_sclk && bus0.o_sclk) begin
      rise_cnt++;
      mosi_seq = {mosi_seq[6:0], bus0.o_mosi};
      if (last_rise >= 0) begin
        if (cyc - last_rise < per_min) per_min = cyc - last_rise;
        if (cyc - last_rise > per_max) per_max = cyc - last_rise;
      end else if (cs_fall >= 0) begin
        first_dly = cyc - cs_fall;
      end
      last_rise = cyc;
      miso_pat = {miso_pat[6:0], 1'b0};
      miso_drv = miso_pat[7];
    end
    prev_sclk = bus0.o_sclk;
    prev_cs   = bus0.o_cs_n;

    if (bus1.o_busy) busy1_cnt++;
    if (!prev1_sclk && bus1.o_sclk) begin
      rise1_cnt++;
      if (last1_rise >= 0) begin
        if (cyc - last1_rise < per1_min) per1_min = cyc - last1_rise;
        if (cyc - last1_rise > per1_max) per1_max = cyc - last1_rise;
      end
      last1_rise = cyc;
    end
    prev1_sclk = bus1.o_sclk;
  end

  // Driver tasks (all stimulus changes on the falling edge).
  task automatic start_frame(input logic [7:0] tx);
    @(negedge clk);
    bus0.i_tx_data = tx;
    bus0.i_start   = 1'b1;
    clear_stats();
    @(negedge clk);
    bus0.i_start   = 1'b0;
    bus0.i_tx_data = ~tx;
    check("accept_cs_n", bus0.o_cs_n, 0);
    check("accept_busy", bus0.o_busy, 1);
  endtask

  task automatic wait_done0();
    int n;
    n = 0;
    while (!bus0.o_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done0_seen", bus0.o_done, 1);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] rx_exp, input logic [7:0] seq_exp);
    check({tag, "_rx"}, bus0.o_rx_data, rx_exp);
    check({tag, "_busy_cycles"}, busy_cnt, 68);
    check({tag, "_rises"}, rise_cnt, 8);
    check({tag, "_mosi_seq"}, mosi_seq, seq_exp);
    check({tag, "_cs_sclk_low"}, cs_viol, 0);
    check({tag, "_done_busy"}, bus0.o_busy, 0);
    check({tag, "_done_cs_n"}, bus0.o_cs_n, 1);
  endtask

  initial begin
    bus0.i_start = 1'b0; bus0.i_tx_data = '0;
    bus1.i_start = 1'b0; bus1.i_tx_data = '0;
    miso_pat = '0;
    clear_stats();

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_sclk", bus0.o_sclk, 0);
    check("rst_mosi", bus0.o_mosi, 0);
    check("rst_cs_n", bus0.o_cs_n, 1);
    check("rst_busy", bus0.o_busy, 0);
    check("rst_done", bus0.o_done, 0);
    check("rst_rx", bus0.o_rx_data, 0);
    check("rst_state", st0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback 0xA5
    start_frame(8'hA5);
    wait_done0();
    check_frame("lb_a5", 8'hA5, 8'hA5);
    check("lb_a5_per_min", per_min, 8);
    check("lb_a5_per_max", per_max, 8);
    check("lb_a5_first_rise", first_dly, 4);
    @(negedge clk);
    check("lb_a5_done_count", done_cnt, 1);
    check("lb_a5_done_pulse", bus0.o_done, 0);

    // Independent MISO 0x3C, tx 0x00
    loop0 = 1'b0;
    miso_pat = 8'h3C;
    miso_drv = 1'b0;
    start_frame(8'h00);
    wait_done0();
    check_frame("ind", 8'h3C, 8'h00);
    check("ind_mosi_zero", mosi_or, 0);
    loop0 = 1'b1;
    repeat (2) @(negedge clk);

    // Start while busy: 0xFF requested mid-frame of 0x81
    start_frame(8'h81);
    repeat (18) @(negedge clk);
    bus0.i_tx_data = 8'hFF;
    bus0.i_start   = 1'b1;
    @(negedge clk);
    bus0.i_start   = 1'b0;
    wait_done0();
    check_frame("busy_start", 8'h81, 8'h81);
    repeat (20) @(negedge clk);
    check("busy_start_cs_n_after", bus0.o_cs_n, 1);
    check("busy_start_busy_total", busy_cnt, 68);
    check("busy_start_done_count", done_cnt, 1);

    // Back-to-back 0xC3 then 0x5A
    start_frame(8'hC3);
    wait_done0();
    check_frame("b2b_1", 8'hC3, 8'hC3);
    bus0.i_tx_data = 8'h5A;
    bus0.i_start   = 1'b1;
    clear_stats();
    @(negedge clk);
    bus0.i_start   = 1'b0;
    check("b2b_cs_gap_one_cycle", bus0.o_cs_n, 0);
    wait_done0();
    check_frame("b2b_2", 8'h5A, 8'h5A);
    repeat (2) @(negedge clk);

    // Reset mid-frame after 3 SCLK rises
    start_frame(8'hF0);
    begin
      int n;
      n = 0;
      while (rise_cnt < 3 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("midrst_reach_3_rises", rise_cnt, 3);
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cs_n", bus0.o_cs_n, 1);
    check("midrst_busy", bus0.o_busy, 0);
    check("midrst_sclk", bus0.o_sclk, 0);
    check("midrst_mosi", bus0.o_mosi, 0);
    check("midrst_rx", bus0.o_rx_data, 0);
    check("midrst_state", st0, 0);
    repeat (3) @(negedge clk);
    check("midrst_no_done", done_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    start_frame(8'h0F);
    wait_done0();
    check_frame("post_rst", 8'h0F, 8'h0F);
    repeat (2) @(negedge clk);

    // 16 bit, CLK_DIV=1 loopback 0xBEEF
    @(negedge clk);
    bus1.i_tx_data = 16'hBEEF;
    bus1.i_start   = 1'b1;
    clear_stats();
    @(negedge clk);
    bus1.i_start   = 1'b0;
    bus1.i_tx_data = 16'h0000;
    check("w16_accept_cs_n", bus1.o_cs_n, 0);
    begin
      int n;
      n = 0;
      while (!bus1.o_done && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("w16_done_seen", bus1.o_done, 1);
    end
    check("w16_rx", bus1.o_rx_data, 16'hBEEF);
    check("w16_busy_cycles", busy1_cnt, 33);
    check("w16_rises", rise1_cnt, 16);
    check("w16_per_min", per1_min, 2);
    check("w16_per_max", per1_max, 2);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
